// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared op encodings, FSM states and constants for the execute stage
package ex_pkg;

    localparam int XLEN  = 32;
    localparam int STEPS = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] DIV0_QUOTIENT = {XLEN{1'b1}};

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier and restoring divider
module muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              abort,
    input  logic              start,
    input  logic              is_div,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    output logic              busy,
    output logic              done,
    output logic [2*XLEN-1:0] acc_next
);

    localparam int CW = $clog2(STEPS);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operand;
    logic              div_mode;
    logic [CW-1:0]     count;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_trial;
    logic [XLEN:0]     rem_diff;

    // Multiply: acc = {partial sum, multiplier}. Divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        rem_trial = acc[2*XLEN-1:XLEN-1];
        rem_diff  = rem_trial - {1'b0, operand};
        if (div_mode) begin
            if (rem_diff[XLEN])
                acc_next = {rem_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_next = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

    assign done = busy && (count == CW'(STEPS - 1));

    always_ff @(posedge clock) begin
        if (reset || abort) begin
            acc      <= '0;
            operand  <= '0;
            div_mode <= 1'b0;
            count    <= '0;
            busy     <= 1'b0;
        end else if (start) begin
            acc      <= {{XLEN{1'b0}}, is_div ? opa : opb};
            operand  <= is_div ? opb : opa;
            div_mode <= is_div;
            count    <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_stage_unit.sv
// rtl/ex_stage_unit.sv - execute stage: single-cycle ALU plus iterative mul/div with stall
module ex_stage_unit
    import ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] data_in_1,
    input  logic [XLEN-1:0] data_in_2,
    input  logic [XLEN-1:0] imm_in,
    input  logic            alusrc_in,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] result_out,
    output logic [4:0]      rd_out
);

    state_t            state;
    logic [3:0]        op_q;
    logic [4:0]        rd_q;
    logic              b_zero;
    logic [XLEN-1:0]   operand_b;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   md_result;
    logic [2*XLEN-1:0] md_acc_next;
    logic              md_busy;
    logic              md_done;
    logic              accept_multi;

    assign operand_b    = alusrc_in ? imm_in : data_in_2;
    assign accept_multi = (state == S_IDLE) && in_valid && is_multicycle(op);
    assign stall        = !reset && (accept_multi || (state == S_BUSY));

    always_comb begin
        alu_result = '0;
        case (op)
            OP_ADD:  alu_result = data_in_1 + operand_b;
            OP_SUB:  alu_result = data_in_1 - operand_b;
            OP_AND:  alu_result = data_in_1 & operand_b;
            OP_OR:   alu_result = data_in_1 | operand_b;
            OP_XOR:  alu_result = data_in_1 ^ operand_b;
            OP_SLL:  alu_result = data_in_1 << operand_b[4:0];
            OP_SRL:  alu_result = data_in_1 >> operand_b[4:0];
            OP_SRA:  alu_result = $signed(data_in_1) >>> operand_b[4:0];
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(data_in_1) < $signed(operand_b)};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, data_in_1 < operand_b};
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        md_result = '0;
        case (op_q)
            OP_MUL:   md_result = md_acc_next[XLEN-1:0];
            OP_MULHU: md_result = md_acc_next[2*XLEN-1:XLEN];
            OP_DIVU:  md_result = b_zero ? DIV0_QUOTIENT : md_acc_next[XLEN-1:0];
            OP_REMU:  md_result = md_acc_next[2*XLEN-1:XLEN];
            default:  md_result = '0;
        endcase
    end

    muldiv_iter #(
        .XLEN  (XLEN),
        .STEPS (STEPS)
    ) u_muldiv (
        .clock    (clock),
        .reset    (reset),
        .abort    (flush),
        .start    (accept_multi && !flush),
        .is_div   ((op == OP_DIVU) || (op == OP_REMU)),
        .opa      (data_in_1),
        .opb      (operand_b),
        .busy     (md_busy),
        .done     (md_done),
        .acc_next (md_acc_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            b_zero     <= 1'b0;
            out_valid  <= 1'b0;
            result_out <= '0;
            rd_out     <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    out_valid <= 1'b0;
                    if (in_valid) begin
                        if (is_multicycle(op)) begin
                            op_q   <= op;
                            rd_q   <= rd_in;
                            b_zero <= (operand_b == '0);
                            state  <= S_BUSY;
                        end else begin
                            result_out <= alu_result;
                            rd_out     <= rd_in;
                            out_valid  <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    if (md_done) begin
                        result_out <= md_result;
                        rd_out     <= rd_q;
                        out_valid  <= 1'b1;
                        state      <= S_DONE;
                    end else if (!md_busy) begin
                        state <= S_IDLE;
                    end
                end
                // ID/EX still holds the finished instruction here, so inputs are ignored.
                S_DONE: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_unit.sv
// tb/tb_ex_stage_unit.sv - directed scoreboard bench for ex_stage_unit
module tb_ex_stage_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [3:0]  op;
    logic [31:0] data_in_1;
    logic [31:0] data_in_2;
    logic [31:0] imm_in;
    logic        alusrc_in;
    logic [4:0]  rd_in;
    logic        stall;
    logic        out_valid;
    logic [31:0] result_out;
    logic [4:0]  rd_out;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    ex_stage_unit dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .op         (op),
        .data_in_1  (data_in_1),
        .data_in_2  (data_in_2),
        .imm_in     (imm_in),
        .alusrc_in  (alusrc_in),
        .rd_in      (rd_in),
        .stall      (stall),
        .out_valid  (out_valid),
        .result_out (result_out),
        .rd_out     (rd_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        if (out_valid === 1'b1) begin
            check("spurious_pulse", {31'b0, sb.size() == 0}, 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("result_out", result_out, e.result);
                check("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
            end
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic src, input logic [4:0] rd);
        in_valid  = 1'b1;
        op        = o;
        data_in_1 = a;
        data_in_2 = b;
        imm_in    = im;
        alusrc_in = src;
        rd_in     = rd;
    endtask

    task automatic run_single(input string tag, input logic [3:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] im, input logic src,
                              input logic [4:0] rd, input logic [31:0] expected);
        drive(o, a, b, im, src, rd);
        sb.push_back('{expected, rd});
        tick();
        check({tag, "_latency"}, sb.size(), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic run_multi(input string tag, input logic [3:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expected);
        int n;
        drive(o, a, b, 32'd0, 1'b0, rd);
        sb.push_back('{expected, rd});
        #1;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check({tag, "_stall_cycles"}, n, 32'd33);
        check({tag, "_done_pulse"}, sb.size(), 32'd0);
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        drive(4'd10, 32'd3, 32'd5, 32'd0, 1'b0, 5'd7);
        repeat (2) @(posedge clock);
        #1;
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result_out, 32'd0);
        check("reset_rd", {27'b0, rd_out}, 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();

        run_single("add_imm", 4'd0, 32'h7FFF_FFFF, 32'h0, 32'd1, 1'b1, 5'd5, 32'h8000_0000);
        run_single("sra", 4'd7, 32'h8000_0000, 32'h0, 32'd4, 1'b1, 5'd6, 32'hF800_0000);
        run_single("sltu", 4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd7, 32'd1);
        tick();
        check("hold_result", result_out, 32'd1);
        run_single("sub_wrap", 4'd1, 32'd0, 32'd1, 32'd0, 1'b0, 5'd1, 32'hFFFF_FFFF);
        run_single("slt_signed", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd2, 32'd1);
        run_single("sll_mask", 4'd5, 32'd1, 32'h0, 32'h3F, 1'b1, 5'd3, 32'h8000_0000);
        run_single("unused_op", 4'd14, 32'h1234, 32'h5678, 32'd0, 1'b0, 5'd4, 32'd0);
        tick();

        run_multi("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE);
        run_multi("mul", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h0000_0001);
        run_multi("divu_zero", 4'd12, 32'd100, 32'd0, 5'd12, 32'hFFFF_FFFF);
        run_multi("remu", 4'd13, 32'd100, 32'd7, 5'd13, 32'd2);
        run_multi("remu_zero", 4'd13, 32'd100, 32'd0, 5'd14, 32'd100);

        drive(4'd12, 32'd1000, 32'd3, 32'd0, 1'b0, 5'd15);
        #1;
        repeat (10) tick();
        check("divu_busy_stall", {31'b0, stall}, 32'd1);
        flush    = 1'b1;
        in_valid = 1'b0;
        tick();
        flush = 1'b0;
        #1;
        check("flush_stall", {31'b0, stall}, 32'd0);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        repeat (40) tick();
        run_single("add_after_flush", 4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd9, 32'd5);
        tick();

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_stage_unit.md
# ex_stage_unit

Execute-stage consumer of the ID/EX pipeline register. It takes decoded operands, immediate, ALU-source select and destination register, and computes the result. Single-cycle ALU ops are registered toward EX/MEM. MUL/MULHU/DIVU/REMU run on an iterative 32-step datapath while the unit back-pressures ID/EX with `stall`.

## Interface
- `XLEN`, 32, datapath width
- `STEPS`, 32, iterations per multi-cycle op (equals `XLEN`)

- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `flush`  in  1  abort in-flight work, suppress output
- `in_valid`  in  1  ID/EX holds a valid instruction
- `op`  in  4  operation code (`ex_pkg`)
- `data_in_1`  in  32  rs1 value
- `data_in_2`  in  32  rs2 value
- `imm_in`  in  32  sign-extended immediate
- `alusrc_in`  in  1  1 selects `imm_in` as operand B
- `rd_in`  in  5  destination register
- `stall`  out  1  hold ID/EX contents (combinational)
- `out_valid`  out  1  `result_out`/`rd_out` valid this cycle
- `result_out`  out  32  result to EX/MEM
- `rd_out`  out  5  destination to EX/MEM

## Operation
- Operand B = `alusrc_in ? imm_in : data_in_2`. Shifts use `B[4:0]`.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT (signed), SLTU. Results wrap modulo 2^32.
- Multi-cycle ops: MUL (low 32 bits), MULHU (high 32 bits of unsigned product), DIVU, REMU.
  - The multiplier is shift-add.
  - The divider is restoring.
- Divide by zero: DIVU returns 0xFFFFFFFF; REMU returns the dividend. There is no early exit; these ops take full latency.
- Unused op codes: `out_valid` pulses with `result_out` = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with `in_valid` and a single-cycle op: register the result, set `out_valid`=1 next cycle, stay in IDLE.
  - IDLE with `in_valid` and a multi-cycle op: latch operands, `rd_in` and op; clear the counter; go to BUSY.
  - BUSY: one iteration per cycle. When the counter reaches `STEPS-1`, register the result and go to DONE.
  - DONE: `out_valid`=1. Inputs are ignored, because ID/EX still holds the completed instruction. Go to IDLE.
- `stall` = (IDLE & `in_valid` & multi-cycle op) | BUSY. It is 0 in DONE and 0 while `reset` is high.
- `flush` (synchronous): go to IDLE, clear the counter, and force `out_valid`=0 next cycle. `flush` wins over a simultaneous `in_valid` and over a BUSY→DONE transition.
- `reset` wins over `flush`. Reset mid-BUSY discards the operation.

## Timing
- Reset values: state IDLE, counter 0, `out_valid` 0, `result_out` 0, `rd_out` 0, `stall` 0.
- Single-cycle op accepted at edge N: result visible after edge N+1, one cycle latency. Back-to-back single-cycle ops sustain one result per cycle.
- Multi-cycle op seen in IDLE during cycle 0:
  - `stall` is high for cycles 0 through 32 (33 cycles).
  - DONE is cycle 33, with `out_valid`=1 and `stall`=0.
  - ID/EX advances at the end of cycle 33.
  - The next instruction is evaluated in IDLE in cycle 34.
- `out_valid` is a one-cycle pulse per accepted instruction. `result_out`/`rd_out` hold their last value when `out_valid`=0.

## Structure
- Shared package `ex_pkg`: op encodings, `is_multicycle` function, FSM state enum, `STEPS` constant, divide-by-zero constants.
- Sub-module `muldiv_iter`: iterative shift-add multiplier and restoring divider. It has `start` / `busy` / `done` signals, a 64-bit accumulator and a step counter.
- The top level owns operand-B selection, the single-cycle ALU, the FSM, `stall` and the output registers.

## Test plan
- Reset: assert `reset` with `in_valid`=1 and op=MUL → `stall`=0, `out_valid`=0, outputs 0.
- ADD with `alusrc_in`=1, `data_in_1`=0x7FFFFFFF, `imm_in`=1, `rd_in`=5 → next cycle `out_valid`=1, `result_out`=0x80000000, `rd_out`=5.
- Back-to-back SRA(0x80000000, B=4) then SLTU(1, 0xFFFFFFFF) → 0xF8000000 then 1 on consecutive cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → `stall` high 33 cycles, then `out_valid` with 0xFFFFFFFE. MUL with the same operands → 0x00000001.
- DIVU 100/0 → 0xFFFFFFFF after 33 cycles. REMU 100/7 → 2.
- `flush` at BUSY cycle 10 of a DIVU → `stall` low next cycle, no `out_valid` pulse. A following ADD completes normally in one cycle.
